// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: word RAM plus a small MMIO window (LED, switches,
// timer with compare interrupt). Read data is registered, one cycle latency.
module data_sram_resp #(
  parameter int unsigned RAM_AW  = 10,
  parameter logic [15:0] MMIO_HI = 16'hbfaf
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch_in,
  output logic [15:0] led,
  output logic        timer_irq
);

  localparam int unsigned DW        = 32;
  localparam int unsigned LANES     = DW / 8;
  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
  localparam int unsigned OFF_W     = 14;

  localparam logic [OFF_W-1:0] OFF_LED   = OFF_W'(0);
  localparam logic [OFF_W-1:0] OFF_SW    = OFF_W'(1);
  localparam logic [OFF_W-1:0] OFF_TIMER = OFF_W'(2);
  localparam logic [OFF_W-1:0] OFF_CMP   = OFF_W'(3);
  localparam logic [OFF_W-1:0] OFF_STAT  = OFF_W'(4);
  localparam logic [OFF_W-1:0] OFF_CTRL  = OFF_W'(5);

  // Byte-lane merge of write data over an existing register value.
  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_val,
                                                input logic [DW-1:0] new_val,
                                                input logic [LANES-1:0] be);
    logic [DW-1:0] res;
    res = old_val;
    for (int i = 0; i < LANES; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  logic [DW-1:0]     ram [RAM_DEPTH];
  logic [RAM_AW-1:0] ram_idx;
  logic [OFF_W-1:0]  mmio_off;
  logic              is_mmio;
  logic              rd_req;
  logic              wr_req;
  logic              unused_addr;

  logic [DW-1:0]     timer;
  logic [DW-1:0]     cmp;
  logic              stat;
  logic              ctrl;
  logic [7:0]        sw_meta;
  logic [7:0]        sw_sync;

  logic              we_led;
  logic              we_timer;
  logic              we_cmp;
  logic              we_stat;
  logic              we_ctrl;
  logic              stat_set;
  logic              stat_clr;
  logic [15:0]       led_next;
  logic [DW-1:0]     timer_wr_val;
  logic [DW-1:0]     cmp_wr_val;
  logic [DW-1:0]     mmio_rdata;

  assign ram_idx     = data_sram_addr[RAM_AW+1:2];
  assign mmio_off    = data_sram_addr[15:2];
  assign is_mmio     = (data_sram_addr[31:16] == MMIO_HI);
  assign rd_req      = data_sram_en && (data_sram_wen == 4'b0);
  assign wr_req      = data_sram_en && (data_sram_wen != 4'b0);
  assign unused_addr = ^data_sram_addr[1:0];

  // MMIO write strobes and merged write values.
  always_comb begin
    we_led       = 1'b0;
    we_timer     = 1'b0;
    we_cmp       = 1'b0;
    we_stat      = 1'b0;
    we_ctrl      = 1'b0;
    if (wr_req && is_mmio) begin
      we_led   = (mmio_off == OFF_LED);
      we_timer = (mmio_off == OFF_TIMER);
      we_cmp   = (mmio_off == OFF_CMP);
      we_stat  = (mmio_off == OFF_STAT);
      we_ctrl  = (mmio_off == OFF_CTRL);
    end
    led_next[15:8] = data_sram_wen[1] ? data_sram_wdata[15:8] : led[15:8];
    led_next[7:0]  = data_sram_wen[0] ? data_sram_wdata[7:0]  : led[7:0];
    timer_wr_val   = merge_bytes(timer, data_sram_wdata, data_sram_wen);
    cmp_wr_val     = merge_bytes(cmp, data_sram_wdata, data_sram_wen);
  end

  // Compare uses the pre-increment timer; a zero compare value never fires.
  assign stat_set  = (timer == cmp) && (cmp != '0);
  assign stat_clr  = we_stat && data_sram_wen[0] && data_sram_wdata[0];
  assign timer_irq = stat & ctrl;

  always_comb begin
    mmio_rdata = '0;
    unique case (mmio_off)
      OFF_LED:   mmio_rdata = {16'b0, led};
      OFF_SW:    mmio_rdata = {24'b0, sw_sync};
      OFF_TIMER: mmio_rdata = timer;
      OFF_CMP:   mmio_rdata = cmp;
      OFF_STAT:  mmio_rdata = {31'b0, stat};
      OFF_CTRL:  mmio_rdata = {31'b0, ctrl};
      default:   mmio_rdata = '0;
    endcase
  end

  // RAM array has no reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (wr_req && !is_mmio && !reset) begin
      for (int i = 0; i < LANES; i++) begin
        if (data_sram_wen[i]) ram[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_sram_rdata <= '0;
    end else if (rd_req) begin
      data_sram_rdata <= is_mmio ? mmio_rdata : ram[ram_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led     <= '0;
      cmp     <= '0;
      ctrl    <= 1'b0;
      timer   <= '0;
      stat    <= 1'b0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch_in;
      sw_sync <= sw_meta;
      if (we_led)  led  <= led_next;
      if (we_cmp)  cmp  <= cmp_wr_val;
      if (we_ctrl && data_sram_wen[0]) ctrl <= data_sram_wdata[0];
      timer <= we_timer ? timer_wr_val : timer + DW'(1);
      // Set has priority over a coincident write-one-to-clear.
      stat  <= stat_set | (stat & ~stat_clr);
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: RAM byte writes, aliasing, MMIO map,
// timer compare interrupt, wrap and asynchronous reset.
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [7:0]  switch_in = 8'h00;
  logic [15:0] led;
  logic        irq;

  int checks = 0;
  int passed = 0;

  localparam logic [31:0] A_LED   = 32'hbfaf0000;
  localparam logic [31:0] A_SW    = 32'hbfaf0004;
  localparam logic [31:0] A_TIMER = 32'hbfaf0008;
  localparam logic [31:0] A_CMP   = 32'hbfaf000c;
  localparam logic [31:0] A_STAT  = 32'hbfaf0010;
  localparam logic [31:0] A_CTRL  = 32'hbfaf0014;

  data_sram_resp dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .switch_in       (switch_in),
    .led             (led),
    .timer_irq       (irq)
  );

  always #5 clk = ~clk;

  // Each call presents one request for the following posedge.
  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    en = e; wen = w; addr = a; wdata = d;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    drive(1'b1, w, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    drive(1'b1, 4'h0, a, 32'h0);
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    // Reset state
    idle();
    check("reset_rdata", rdata, 32'h0);
    check("reset_led", 32'(led), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    reset = 1'b0;

    // RAM byte-lane writes, rdata must hold through the writes
    wr(32'h40, 32'h11223344, 4'hf);
    wr(32'h40, 32'h0000aa00, 4'b0010);
    check("rdata_hold_w1", rdata, 32'h0);
    rd(32'h40);
    check("rdata_hold_w2", rdata, 32'h0);
    idle();
    check("ram_byte_merge", rdata, 32'h1122aa44);

    // Aliasing, read-after-write, back-to-back reads
    wr(32'h08, 32'h0badf00d, 4'hf);
    wr(32'h04, 32'hdeadbeef, 4'hf);
    rd(32'h1004);
    rd(32'h08);
    check("alias_rd", rdata, 32'hdeadbeef);
    idle();
    check("b2b_rd", rdata, 32'h0badf00d);

    // LED and switch synchroniser
    wr(A_LED, 32'hffff5a5a, 4'hf);
    rd(A_LED);
    check("led_out", 32'(led), 32'h5a5a);
    idle();
    check("led_rd", rdata, 32'h00005a5a);
    switch_in = 8'hc3;
    idle();
    idle();
    rd(A_SW);
    idle();
    check("switch_rd", rdata, 32'h000000c3);

    // Timer compare interrupt: 0x10 reaches 0x20 after 16 edges, STAT on the 17th
    wr(A_CTRL, 32'h1, 4'hf);
    wr(A_CMP, 32'h20, 4'hf);
    wr(A_TIMER, 32'h10, 4'hf);
    for (int i = 0; i < 17; i++) idle();
    check("irq_before", 32'(irq), 32'h0);
    idle();
    check("irq_rise", 32'(irq), 32'h1);
    rd(A_STAT);
    wr(A_STAT, 32'h1, 4'h1);
    check("stat_rd", rdata, 32'h1);
    idle();
    check("irq_clear", 32'(irq), 32'h0);

    // Set and clear in the same cycle: set wins
    wr(A_TIMER, 32'h20, 4'hf);
    wr(A_STAT, 32'h1, 4'h1);
    idle();
    check("race_irq", 32'(irq), 32'h1);
    rd(A_STAT);
    wr(A_STAT, 32'h1, 4'h1);
    check("race_stat", rdata, 32'h1);
    wr(A_CMP, 32'h0, 4'hf);
    check("race_cleared", 32'(irq), 32'h0);

    // Timer wrap with CMP=0: no interrupt at timer==0
    wr(A_TIMER, 32'hfffffffe, 4'hf);
    idle();
    idle();
    rd(A_TIMER);
    rd(A_STAT);
    check("timer_wrap", rdata, 32'h0);
    idle();
    check("wrap_stat", rdata, 32'h0);
    check("wrap_irq", 32'(irq), 32'h0);

    // Async reset in the middle of a write burst
    wr(A_CMP, 32'h40, 4'hf);
    wr(A_TIMER, 32'h40, 4'hf);
    wr(A_LED, 32'h1234, 4'hf);
    rd(A_LED);
    idle();
    check("pre_rst_rdata", rdata, 32'h1234);
    check("pre_rst_irq", 32'(irq), 32'h1);
    wr(32'h100, 32'h55555555, 4'hf);
    #2 reset = 1'b1;
    #1;
    check("rst_led", 32'(led), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    wr(32'h40, 32'hffffffff, 4'hf);
    idle();
    reset = 1'b0;
    idle();
    rd(A_TIMER);
    idle();
    check("timer_from_0", rdata, 32'h2);
    check("led_after_rst", 32'(led), 32'h0);
    rd(32'h40);
    idle();
    check("ram_wr_discarded", rdata, 32'h1122aa44);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
